clk_divider_multi: RTL
======================

# clk_divider_multi

Multi-channel, run-time programmable clock divider, the parametrised successor to the fixed single-output divider. Each of CHANNELS independent channels divides clk by a programmable ratio, with programmable high time (odd ratios and arbitrary duty cycle supported), and emits a one-cycle end-of-period tick. Configuration arrives over a valid/ready write port. Updates are applied glitch-free at the channel's period boundary. It sits beside the system clock as the source of slow strobes and derived enables for display scan, debouncing and serial timing.

## Interface
- WIDTH, 16: width of counter, divide and high-time values.
- CHANNELS, 4: number of independent channels; CW = max(1, $clog2(CHANNELS)).
- DEFAULT_DIV, 16: divide ratio after reset, 2 ≤ DEFAULT_DIV < 2^WIDTH.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  write accepted this cycle when high together with cfg_valid.
- cfg_chan  input  CW  target channel.
- cfg_div  input  WIDTH  divide ratio (period in clk cycles).
- cfg_high  input  WIDTH  clk_out high cycles per period.
- cfg_enable  input  1  channel enable.
- clk_out  output  CHANNELS  divided clocks, registered.
- tick  output  CHANNELS  one-cycle pulse per period, registered.
- pending  output  CHANNELS  channel holds an accepted update not yet applied.

## Operation
- Per-channel state:
  - counter
  - active div/high/enable
  - shadow div/high
  - pending flag
- Reset: counter = 0, div = DEFAULT_DIV, high = DEFAULT_DIV/2, enable = 1, pending = 0. Outputs clk_out = 0, tick = 0, pending = 0.
- Enabled channel, each edge:
  - counter <= (counter == div-1) ? 0 : counter+1.
  - clk_out <= (counter < high).
  - tick <= (counter == div-1).
- Disabled channel: counter held 0, clk_out <= 0, tick <= 0.
- Clamping on write: cfg_div < 2 is stored as 2; cfg_high > div is stored as div (constant high); cfg_high = 0 gives constant low, with tick still running.
- cfg_ready = !pending[cfg_chan]. If cfg_chan ≥ CHANNELS, cfg_ready = 1 and the write is dropped.
- Accepted write, cfg_enable = 1, channel currently enabled: shadow <= values and pending <= 1. At the next edge where counter == div-1 (counter wraps), the shadow values are copied to the active registers and pending clears.
- Accepted write, cfg_enable = 1, channel disabled: values are loaded into the active registers immediately. enable <= 1, counter restarts at 0, pending stays 0.
- Accepted write, cfg_enable = 0: the channel is disabled immediately. Counter goes to 0, any pending update is discarded, and pending clears.
- A write accepted on the same edge the channel wraps does not apply at that wrap; it applies at the following wrap.
- Wrap detection uses the active div only; shadow values never affect the period in progress.

## Timing
- clk_out and tick lag the counter by one cycle (registered).
- First edge after reset release, defaults: clk_out = 1 for 8 cycles, then 0 for 8 cycles, period 16. The first tick comes 16 cycles after release, coincident with the final low cycle.
- Period is exactly div cycles; high time is exactly min(high, div) cycles. No runt pulses at reconfiguration.
- Update latency: from the accept edge to the new period start, at most div cycles (old div).
- Enable from disabled: the clk_out high phase begins at the second edge after accept.
- Disable: clk_out and tick are 0 from the second edge after accept.
- Reset mid-operation overrides everything and returns the reset values on that edge.
- Channels are fully independent; writes to one never perturb another's counter.

## Test plan
- Reset, defaults, CHANNELS = 4: every channel shows period 16, high 8, and tick once per 16 cycles; all channels are phase-aligned.
- Program ch1 div = 5, high = 2 mid-period: ch1 pending = 1 until the old period ends, then the period is 5 with 2 high / 3 low, with no short pulse. Other channels are unchanged.
- Back-to-back writes to ch2: the second write is held by cfg_ready = 0 until ch2 wraps, then accepted. Final settings are those of the second write.
- Clamping: div = 1, high = 0 gives a period of 2 with clk_out constantly 0 and tick every 2 cycles. div = 3, high = 7 gives clk_out constantly 1.
- Disable ch0 then re-enable with div = 4, high = 1: clk_out and tick go to 0 two edges after the disable. After the enable, the pattern is 1,0,0,0 repeating, starting at the second edge after accept.
- Assert reset mid-period while ch3 is pending: all outputs are 0, pending is cleared, and the default period-16 pattern resumes after release.

Source files
------------

// File: rtl/clk_divider_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clk_divider_multi
//  Purpose  : Multi-channel run-time programmable clock divider. Each channel
//             divides clk by a programmable ratio with programmable high time
//             and emits a one-cycle end-of-period tick. Settings written
//             while a channel runs are shadowed and take effect at its next
//             period boundary, so no runt pulses are produced.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_divider_multi #(
   parameter int  WIDTH       = 16,
   parameter int  CHANNELS    = 4,
   parameter int  DEFAULT_DIV = 16,
   localparam int CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cfg_valid_i,
   output logic                cfg_ready_o,
   input  logic [CW-1:0]       cfg_chan_i,
   input  logic [WIDTH-1:0]    cfg_div_i,
   input  logic [WIDTH-1:0]    cfg_high_i,
   input  logic                cfg_enable_i,
   output logic [CHANNELS-1:0] clk_out_o,
   output logic [CHANNELS-1:0] tick_o,
   output logic [CHANNELS-1:0] pending_o
);

   localparam logic [WIDTH-1:0] C_DEF_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] C_DEF_HIGH = WIDTH'(DEFAULT_DIV / 2);
   localparam logic [WIDTH-1:0] C_MIN_DIV  = WIDTH'(2);
   localparam logic [WIDTH-1:0] C_ONE      = WIDTH'(1);

   logic [WIDTH-1:0] div_clamp;
   logic [WIDTH-1:0] high_clamp;

   // Clamp the incoming settings once; every channel loads the clamped form
   always_comb begin
      div_clamp  = (cfg_div_i < C_MIN_DIV) ? C_MIN_DIV : cfg_div_i;
      high_clamp = (cfg_high_i > div_clamp) ? div_clamp : cfg_high_i;
   end

   // A channel holding an unapplied update refuses further writes; writes to
   // a non-existent channel are accepted and silently dropped
   always_comb begin
      cfg_ready_o = 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
         if ((cfg_chan_i == CW'(c)) && pending_o[c]) begin
            cfg_ready_o = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      logic [WIDTH-1:0] cnt_q,   cnt_d;
      logic [WIDTH-1:0] div_q,   div_d;
      logic [WIDTH-1:0] high_q,  high_d;
      logic [WIDTH-1:0] sdiv_q,  sdiv_d;
      logic [WIDTH-1:0] shigh_q, shigh_d;
      logic             en_q,    en_d;
      logic             pend_q,  pend_d;
      logic             clk_q,   clk_d;
      logic             tick_q,  tick_d;
      logic             wr;
      logic             wrap;

      // The ready term is folded in so a refused write never disturbs state
      assign wr   = cfg_valid_i && (cfg_chan_i == CW'(g)) && !pend_q;
      assign wrap = en_q && (cnt_q == (div_q - C_ONE));

      // Next-state: counter, active/shadow settings and registered outputs
      always_comb begin
         cnt_d   = cnt_q;
         div_d   = div_q;
         high_d  = high_q;
         sdiv_d  = sdiv_q;
         shigh_d = shigh_q;
         en_d    = en_q;
         pend_d  = pend_q;
         clk_d   = en_q && (cnt_q < high_q);
         tick_d  = wrap;

         if (wr && !cfg_enable_i) begin
            // Disable takes effect at once and drops any queued update
            en_d   = 1'b0;
            cnt_d  = '0;
            pend_d = 1'b0;
         end else if (wr && !en_q) begin
            // Nothing is running, so there is no period to protect
            div_d  = div_clamp;
            high_d = high_clamp;
            en_d   = 1'b1;
            cnt_d  = '0;
         end else if (en_q) begin
            if (wrap) begin
               cnt_d = '0;
               if (pend_q) begin
                  div_d  = sdiv_q;
                  high_d = shigh_q;
                  pend_d = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + C_ONE;
            end
            // wr implies no update was pending, so this never collides with
            // the apply above; a write on a wrap edge waits for the next wrap
            if (wr) begin
               sdiv_d  = div_clamp;
               shigh_d = high_clamp;
               pend_d  = 1'b1;
            end
         end else begin
            cnt_d = '0;
         end
      end

      // State register with synchronous reset to the power-on defaults
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q   <= '0;
            div_q   <= C_DEF_DIV;
            high_q  <= C_DEF_HIGH;
            sdiv_q  <= C_DEF_DIV;
            shigh_q <= C_DEF_HIGH;
            en_q    <= 1'b1;
            pend_q  <= 1'b0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
         end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            high_q  <= high_d;
            sdiv_q  <= sdiv_d;
            shigh_q <= shigh_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
         end
      end

      assign clk_out_o[g] = clk_q;
      assign tick_o[g]    = tick_q;
      assign pending_o[g] = pend_q;
   end

endmodule
`default_nettype wire
